// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: tag/count widths and the entry payload.
package reorder_buffer_pkg;

  localparam int unsigned ROB_TAG_W = 5;
  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned ROB_CNT_W = ROB_TAG_W + 1;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned XLEN      = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ROB_CNT_W-1:0] rob_cnt_t;
  typedef logic [REG_W-1:0]     reg_id_t;
  typedef logic [XLEN-1:0]      xlen_t;

  typedef struct packed {
    logic    busy;
    logic    ready;
    reg_id_t rd;
    logic    has_dest;
    logic    is_branch;
    logic    pred_taken;
    xlen_t   alt_pc;
    xlen_t   val;
    logic    taken;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates rename tags, captures CDB results,
// retires one instruction per cycle into the register file and flushes on mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic     clk,
  input  logic     rst,

  input  logic     issue_valid,
  output logic     issue_ready,
  input  reg_id_t  issue_rd,
  input  logic     issue_has_dest,
  input  logic     issue_is_branch,
  input  logic     issue_pred_taken,
  input  xlen_t    issue_alt_pc,
  output rob_tag_t alloc_tag,

  output logic     dependency_set_en,
  output reg_id_t  dependency_reg,
  output rob_tag_t dependency_dependency,

  input  logic     cdb_valid,
  input  rob_tag_t cdb_tag,
  input  xlen_t    cdb_val,
  input  logic     cdb_taken,

  input  rob_tag_t q1_tag,
  input  rob_tag_t q2_tag,
  output logic     q1_ready,
  output logic     q2_ready,
  output xlen_t    q1_val,
  output xlen_t    q2_val,

  output logic     write_en,
  output rob_tag_t write_dependency,
  output reg_id_t  write_id,
  output xlen_t    write_val,

  output logic     flush,
  output xlen_t    redirect_pc
);

  rob_tag_t   head_q, head_d;
  rob_tag_t   tail_q, tail_d;
  rob_cnt_t   count_q, count_d;
  rob_entry_t entry_q [ROB_DEPTH];
  rob_entry_t entry_d [ROB_DEPTH];

  rob_entry_t head_e;
  logic       commit_ok;
  logic       issue_fire;
  logic       q1_hit, q2_hit;

  // Retirement is decided purely from registered head state.
  assign head_e    = entry_q[head_q];
  assign commit_ok = (count_q != '0) && head_e.busy && head_e.ready;
  assign flush     = commit_ok && head_e.is_branch && (head_e.taken != head_e.pred_taken);
  assign redirect_pc = flush ? head_e.alt_pc : '0;

  assign write_en         = commit_ok && head_e.has_dest && !head_e.is_branch && (head_e.rd != '0);
  assign write_dependency = head_q;
  assign write_id         = head_e.rd;
  assign write_val        = head_e.val;

  // A slot freed by this cycle's commit only becomes usable next cycle.
  assign issue_ready = (count_q < rob_cnt_t'(ROB_DEPTH)) && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign alloc_tag   = tail_q;

  assign dependency_set_en     = issue_fire && issue_has_dest && (issue_rd != '0);
  assign dependency_reg        = issue_rd;
  assign dependency_dependency = tail_q;

  // Operand lookup forwards a same-cycle CDB broadcast.
  assign q1_hit   = cdb_valid && (cdb_tag == q1_tag);
  assign q2_hit   = cdb_valid && (cdb_tag == q2_tag);
  assign q1_ready = entry_q[q1_tag].busy && (entry_q[q1_tag].ready || q1_hit);
  assign q2_ready = entry_q[q2_tag].busy && (entry_q[q2_tag].ready || q2_hit);
  assign q1_val   = q1_hit ? cdb_val : entry_q[q1_tag].val;
  assign q2_val   = q2_hit ? cdb_val : entry_q[q2_tag].val;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    entry_d = entry_q;

    if (cdb_valid && entry_q[cdb_tag].busy) begin
      entry_d[cdb_tag].ready = 1'b1;
      entry_d[cdb_tag].val   = cdb_val;
      entry_d[cdb_tag].taken = cdb_taken;
    end

    if (commit_ok) begin
      entry_d[head_q].busy = 1'b0;
      head_d = head_q + rob_tag_t'(1);
    end

    if (issue_fire) begin
      entry_d[tail_q] = '{busy:       1'b1,
                          ready:      1'b0,
                          rd:         issue_rd,
                          has_dest:   issue_has_dest,
                          is_branch:  issue_is_branch,
                          pred_taken: issue_pred_taken,
                          alt_pc:     issue_alt_pc,
                          val:        '0,
                          taken:      1'b0};
      tail_d = tail_q + rob_tag_t'(1);
    end

    count_d = count_q + rob_cnt_t'(issue_fire) - rob_cnt_t'(commit_ok);

    // Mispredict discards every in-flight instruction.
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_d[i].busy  = 1'b0;
        entry_d[i].ready = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected commits/flushes,
// a negedge monitor pops and compares whenever the DUT retires or flushes.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     issue_valid = 1'b0;
  logic     issue_ready;
  reg_id_t  issue_rd = '0;
  logic     issue_has_dest = 1'b0;
  logic     issue_is_branch = 1'b0;
  logic     issue_pred_taken = 1'b0;
  xlen_t    issue_alt_pc = '0;
  rob_tag_t alloc_tag;
  logic     dependency_set_en;
  reg_id_t  dependency_reg;
  rob_tag_t dependency_dependency;
  logic     cdb_valid = 1'b0;
  rob_tag_t cdb_tag = '0;
  xlen_t    cdb_val = '0;
  logic     cdb_taken = 1'b0;
  rob_tag_t q1_tag = '0;
  rob_tag_t q2_tag = '0;
  logic     q1_ready, q2_ready;
  xlen_t    q1_val, q2_val;
  logic     write_en;
  rob_tag_t write_dependency;
  reg_id_t  write_id;
  xlen_t    write_val;
  logic     flush;
  xlen_t    redirect_pc;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .issue_has_dest(issue_has_dest), .issue_is_branch(issue_is_branch),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .alloc_tag(alloc_tag),
    .dependency_set_en(dependency_set_en), .dependency_reg(dependency_reg),
    .dependency_dependency(dependency_dependency),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_taken(cdb_taken),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .write_en(write_en), .write_dependency(write_dependency), .write_id(write_id),
    .write_val(write_val),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] flush_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] tag, input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Monitor: every retirement write and every flush must match the scoreboard.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] pc;
    if (!rst && write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit_unexpected: got tag=%0d rd=%0d val=%0h want no commit",
                 write_dependency, write_id, write_val);
      end else begin
        e = exp_q.pop_front();
        chk("commit_tag", 32'(write_dependency), 32'(e.tag));
        chk("commit_rd",  32'(write_id),         32'(e.rd));
        chk("commit_val", write_val,             e.val);
      end
    end
    if (!rst && flush === 1'b1) begin
      if (flush_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL flush_unexpected: got redirect=%0h want no flush", redirect_pc);
      end else begin
        pc = flush_q.pop_front();
        chk("redirect_pc", redirect_pc, pc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    issue_valid      = 1'b0;
    issue_rd         = '0;
    issue_has_dest   = 1'b0;
    issue_is_branch  = 1'b0;
    issue_pred_taken = 1'b0;
    issue_alt_pc     = '0;
    cdb_valid        = 1'b0;
    cdb_tag          = '0;
    cdb_val          = '0;
    cdb_taken        = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic has_dest, input logic br,
                       input logic pt, input logic [31:0] alt);
    issue_valid      = 1'b1;
    issue_rd         = rd;
    issue_has_dest   = has_dest;
    issue_is_branch  = br;
    issue_pred_taken = pt;
    issue_alt_pc     = alt;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input logic taken);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_val   = val;
    cdb_taken = taken;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_write_en",    32'(write_en),    32'd0);
    chk("rst_flush",       32'(flush),       32'd0);
    chk("rst_dep_set",     32'(dependency_set_en), 32'd0);
    chk("rst_redirect",    redirect_pc,      32'd0);
    chk("rst_q1_ready",    32'(q1_ready),    32'd0);
    chk("rst_alloc_tag",   32'(alloc_tag),   32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] vals3 [3];
    vals3[0] = 32'h11;
    vals3[1] = 32'h22;
    vals3[2] = 32'h33;

    // Basic issue, out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      issue(5'(i + 1), 1'b1, 1'b0, 1'b0, 32'h0);
      push_exp(5'(i), 5'(i + 1), vals3[i]);
      settle();
      chk("alloc_tag",    32'(alloc_tag),             32'(i));
      chk("dep_set_en",   32'(dependency_set_en),     32'd1);
      chk("dep_tag",      32'(dependency_dependency), 32'(i));
      chk("dep_reg",      32'(dependency_reg),        32'(i + 1));
      chk("no_commit_issue", 32'(write_en),           32'd0);
    end
    next_cycle(); cdb(5'd1, 32'h22, 1'b0); settle();
    chk("head_not_ready", 32'(write_en), 32'd0);
    next_cycle(); cdb(5'd0, 32'h11, 1'b0); settle();
    chk("cdb_same_cycle_no_commit", 32'(write_en), 32'd0);
    next_cycle(); settle();
    chk("commit_latency", 32'(write_en), 32'd1);
    next_cycle(); settle();
    chk("commit_second", 32'(write_en), 32'd1);
    next_cycle(); cdb(5'd2, 32'h33, 1'b0); settle();
    chk("tag2_wait", 32'(write_en), 32'd0);
    next_cycle();
    next_cycle(); settle();
    chk("idle_no_commit", 32'(write_en), 32'd0);
    chk("phase1_drained", 32'(exp_q.size()), 32'd0);

    // Fill to 32 entries, then commit-and-issue in the same cycle.
    do_reset();
    push_exp(5'd0, 5'd1, 32'hF0);
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      issue(5'((i % 31) + 1), 1'b1, 1'b0, 1'b0, 32'h0);
      settle();
      chk("fill_alloc_tag", 32'(alloc_tag),   32'(i));
      chk("fill_ready",     32'(issue_ready), 32'd1);
    end
    next_cycle(); cdb(5'd0, 32'hF0, 1'b0); settle();
    chk("full_not_ready", 32'(issue_ready), 32'd0);
    next_cycle(); issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0); settle();
    chk("stall_on_commit", 32'(issue_ready), 32'd0);
    chk("full_commit",     32'(write_en),    32'd1);
    next_cycle(); issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0); settle();
    chk("accept_after_commit", 32'(issue_ready), 32'd1);
    chk("wrap_alloc_tag",      32'(alloc_tag),   32'd0);
    next_cycle(); settle();
    chk("full_again", 32'(issue_ready), 32'd0);
    chk("phase2_drained", 32'(exp_q.size()), 32'd0);

    // Mispredicted branch with younger completed work, then recovery.
    do_reset();
    next_cycle(); issue(5'd0, 1'b0, 1'b1, 1'b0, 32'h100); settle();
    chk("branch_no_rename", 32'(dependency_set_en), 32'd0);
    next_cycle(); issue(5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle(); issue(5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle(); cdb(5'd1, 32'h55, 1'b0); settle();
    chk("younger_blocked", 32'(write_en), 32'd0);
    next_cycle(); cdb(5'd0, 32'h0, 1'b1); settle();
    chk("flush_not_yet", 32'(flush), 32'd0);
    next_cycle(); issue(5'd9, 1'b1, 1'b0, 1'b0, 32'h0); flush_q.push_back(32'h100); settle();
    chk("flush_raised",     32'(flush),       32'd1);
    chk("flush_redirect",   redirect_pc,      32'h100);
    chk("branch_no_write",  32'(write_en),    32'd0);
    chk("flush_block_issue", 32'(issue_ready), 32'd0);
    next_cycle(); issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h0); settle();
    chk("flush_one_cycle",  32'(flush),       32'd0);
    chk("post_flush_tag",   32'(alloc_tag),   32'd0);
    chk("post_flush_ready", 32'(issue_ready), 32'd1);
    chk("post_flush_no_commit", 32'(write_en), 32'd0);
    chk("x0_no_rename",     32'(dependency_set_en), 32'd0);
    next_cycle(); issue(5'd7, 1'b1, 1'b0, 1'b0, 32'h0); cdb(5'd0, 32'h77, 1'b0);
    push_exp(5'd1, 5'd7, 32'h99); settle();
    chk("post_flush_tag1", 32'(alloc_tag), 32'd1);
    next_cycle(); cdb(5'd1, 32'h99, 1'b0); settle();
    chk("x0_commit_silent", 32'(write_en), 32'd0);
    next_cycle(); settle();
    chk("head_advanced", 32'(write_en), 32'd1);
    next_cycle(); issue(5'd0, 1'b0, 1'b1, 1'b1, 32'h200); settle();
    chk("branch2_tag", 32'(alloc_tag), 32'd2);
    next_cycle(); cdb(5'd2, 32'h0, 1'b1);
    next_cycle(); settle();
    chk("good_branch_no_flush", 32'(flush),    32'd0);
    chk("good_branch_no_write", 32'(write_en), 32'd0);

    // Operand lookup with CDB forwarding.
    next_cycle(); issue(5'd8,  1'b1, 1'b0, 1'b0, 32'h0); push_exp(5'd3, 5'd8,  32'h3);
    next_cycle(); issue(5'd9,  1'b1, 1'b0, 1'b0, 32'h0); push_exp(5'd4, 5'd9,  32'h4);
    next_cycle(); issue(5'd10, 1'b1, 1'b0, 1'b0, 32'h0); push_exp(5'd5, 5'd10, 32'hABCD);
    settle();
    chk("op_tag5_alloc", 32'(alloc_tag), 32'd5);
    next_cycle(); q1_tag = 5'd5; q2_tag = 5'd4; cdb(5'd5, 32'hABCD, 1'b0); settle();
    chk("q1_fwd_ready", 32'(q1_ready), 32'd1);
    chk("q1_fwd_val",   q1_val,        32'hABCD);
    chk("q2_pending",   32'(q2_ready), 32'd0);
    next_cycle(); settle();
    chk("q1_stored_ready", 32'(q1_ready), 32'd1);
    chk("q1_stored_val",   q1_val,        32'hABCD);
    chk("op_head_wait",    32'(write_en), 32'd0);
    next_cycle(); q1_tag = 5'd9; settle();
    chk("q1_not_busy", 32'(q1_ready), 32'd0);
    next_cycle(); cdb(5'd3, 32'h3, 1'b0);
    next_cycle(); cdb(5'd4, 32'h4, 1'b0);
    for (int i = 0; i < 4; i++) next_cycle();
    settle();
    chk("final_commits_drained", 32'(exp_q.size()),   32'd0);
    chk("final_flushes_drained", 32'(flush_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement stage directly upstream of the register file.
- Allocates a 5-bit rename tag per dispatched instruction and drives the register file's dependency-set port.
- Captures results from the common data bus (CDB) and retires one instruction per cycle in program order into the register file write port.
- Raises a flush, which also drives the register file dependency reset, when a branch retires mispredicted.

Parameters:
- ROB_TAG_W, 5, tag width; must equal the register file dependency width.
- ROB_DEPTH, 32, entry count; always 2**ROB_TAG_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  dispatch presents an instruction
- issue_ready  out  1  ROB can accept an instruction this cycle
- issue_rd  in  5  destination register
- issue_has_dest  in  1  instruction writes issue_rd
- issue_is_branch  in  1  instruction is a conditional branch
- issue_pred_taken  in  1  predicted direction
- issue_alt_pc  in  32  redirect target used if the prediction is wrong
- alloc_tag  out  5  tag given to the issuing instruction (equals tail)
- dependency_set_en  out  1  to register file: mark rd renamed
- dependency_reg  out  5  to register file
- dependency_dependency  out  5  to register file; equals alloc_tag
- cdb_valid  in  1  result broadcast
- cdb_tag  in  5  producing tag
- cdb_val  in  32  result value
- cdb_taken  in  1  resolved branch direction
- q1_tag, q2_tag  in  5 each  operand tags to look up
- q1_ready, q2_ready  out  1 each  tagged value available
- q1_val, q2_val  out  32 each  tagged value
- write_en  out  1  to register file: commit write
- write_dependency  out  5  committing tag
- write_id  out  5  committing rd
- write_val  out  32  committing value
- flush  out  1  mispredict flush; also drives register file dependency_rst
- redirect_pc  out  32  fetch restart PC, valid while flush=1

Behaviour:
- Reset (rst=1 at posedge):
  - head=tail=count=0; all busy and ready bits cleared.
  - Outputs combinational from state, so after reset: issue_ready=1, write_en=0, flush=0, dependency_set_en=0, redirect_pc=0, q*_ready=0.
  - rst dominates every other input in the same cycle.
- Entry fields: busy, ready, rd, has_dest, is_branch, pred_taken, alt_pc, val, taken.
- Pointers are ROB_TAG_W bits and wrap 31→0 naturally. count is 6 bits.
  - Full: count==32. Empty: count==0.
- Issue:
  - issue_ready = (count<32) && !flush. A commit in the same cycle does NOT free a slot for this cycle's issue.
  - Fire = issue_valid && issue_ready. On fire, write the entry at tail with busy=1, ready=0; tail++.
  - dependency_set_en = fire && issue_has_dest && issue_rd!=0. Rename of x0 is suppressed.
- CDB capture:
  - cdb_valid with busy[cdb_tag] sets ready=1, val=cdb_val, taken=cdb_taken at the edge.
  - A CDB hit on a non-busy tag is ignored.
  - A CDB hit and a commit of the same tag in the same cycle cannot occur: commit requires registered ready.
- Commit, purely combinational from head:
  - commit_ok = count>0 && busy[head] && ready[head].
  - write_en = commit_ok && has_dest && rd!=0.
  - write_dependency=head, write_id=rd, write_val=val.
  - On commit_ok: busy[head]=0, head++.
  - Minimum latency: CDB in cycle N → write_en in cycle N+1.
- count update:
  - +1 on issue fire, −1 on commit_ok.
  - Both in the same cycle: count unchanged.
- Mispredict:
  - flush = commit_ok && is_branch && taken!=pred_taken; redirect_pc = alt_pc.
  - At that edge all busy/ready bits clear, head=tail=count=0, and the issue is blocked (issue_ready=0).
  - A branch never has write_en.
  - Correct branches retire silently.
- Operand lookup:
  - qN_ready = busy[qN_tag] && (ready[qN_tag] || (cdb_valid && cdb_tag==qN_tag)).
  - qN_val takes the CDB value on a same-cycle hit, otherwise the stored val.
  - A non-busy tag gives ready=0.
- One instruction per cycle for each of issue, CDB and commit.

Decomposition:
- Shared package holds:
  - ROB_TAG_W=5, ROB_DEPTH=32.
  - A typedef for the tag type.
  - A packed struct for rob_entry_t (fields above).
- Single module. The entry array stays inline; no sub-module is warranted.

Test Plan:
- Reset → issue three instr (rd=1,2,3) → alloc_tag 0,1,2; dependency_set_en each cycle, dependency_dependency 0,1,2; write_en=0.
- CDB tag1 val=0x22 before tag0 (val=0x11 next cycle) → commits in order: tag0/rd1/0x11, then tag1/rd2/0x22; no commit while head is not ready.
- Issue 32 with no CDB → issue_ready=0 at count=32. Complete tag0, then issue same cycle as its commit → stalled that cycle, accepted next with alloc_tag=0 (wrap).
- Branch pred_taken=0, CDB taken=1, alt_pc=0x100, younger entries in flight → flush=1, redirect_pc=0x100 for one cycle; next cycle count=0, alloc_tag=0, no younger commit.
- Issue rd=0 → dependency_set_en=0; on its commit write_en=0 while head still advances.
- q1_tag=5 busy and not ready, with a same-cycle CDB hit tag5 val=0xABCD → q1_ready=1, q1_val=0xABCD; q1_tag not busy → q1_ready=0.
